aes_spi_frontend: RTL
=====================

# aes_spi_frontend

SPI-slave front end for `aes_core`: oversamples a slow SPI bus in the `clk` domain and shifts in a 256-bit frame of plaintext followed by key. It then pulses `load` to `aes_core`, captures `cyphertext` on `done`, and shifts the 128-bit result back out on `sdo`. This block sits directly upstream of `aes_core` and also consumes its outputs, so the MCU only ever sees SPI pins plus a `ready` flag.

## Interface
- `SYNC_STAGES`, 2: flop depth of the input synchronizers on `sck`, `sdi`, `ce`; minimum 2.
- `BLOCK_BITS`, 128: width of plaintext, key and cyphertext; frame length is 2*BLOCK_BITS.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock from MCU, asynchronous; mode 0 (sample on rising edge, change on falling edge).
- `sdi`  in  1  SPI data in, MSB first.
- `ce`  in  1  chip enable, active high, asynchronous; frames a transfer.
- `sdo`  out  1  SPI data out, MSB first.
- `ready`  out  1  cyphertext available for readout.
- `frame_err`  out  1  sticky: last receive frame bit count was not 256.
- `load`  out  1  start pulse to `aes_core`.
- `plaintext`  out  BLOCK_BITS  to `aes_core`.
- `key`  out  BLOCK_BITS  to `aes_core`.
- `done`  in  1  from `aes_core`; level, valid when high.
- `cyphertext`  in  BLOCK_BITS  from `aes_core`; valid while `done` is high.

## Operation
- `sck`, `sdi` and `ce` pass through SYNC_STAGES flops. Edges are detected on the synchronized copies using one extra history flop.
- States are IDLE, RX, START, WAIT, READY, TX.
- IDLE: on `ce` rise, go to RX, clear the 9-bit bit counter and `frame_err`.
- RX: on each `sck` rise, shift `sdi` into the 256-bit register `{plaintext,key}` LSB-side and increment the counter, saturating at 511.
  - Plaintext is sent first, each word MSB first.
  - On `ce` fall with count == 256: go to START.
  - On `ce` fall with any other count: set `frame_err`, leave `key` and `plaintext` unchanged (shift into a staging register; copy to outputs only on a good frame), return to IDLE.
- START: `load`=1 for exactly one cycle, then WAIT.
- WAIT: all SPI activity is ignored. On `done`=1, copy `cyphertext` into the hold register and the 128-bit tx shift register, set `ready`, go to READY.
- READY: on `ce` rise, go to TX.
- TX:
  - `sdo` = tx_shift[127].
  - On each `sck` fall, shift left, fill 0, and increment the counter.
  - On `ce` fall with count ≥ 128: clear `ready`, go to IDLE.
  - On `ce` fall with count < 128: reload tx_shift from the hold register and return to READY, so the readout restarts from bit 127.
- If the `ce` edge and the final `sck` edge land in the same cycle, the `sck` edge is processed first, then the `ce` transition.
- `sdo` is 0 in every state except TX and READY. In READY it already presents bit 127.

## Timing
- Reset values: `sdo`=0, `ready`=0, `frame_err`=0, `load`=0, `key`=0, `plaintext`=0, state IDLE, counter 0.
- Reset mid-frame or mid-encryption discards everything and returns to IDLE next cycle. A later `done` is ignored until a new frame completes.
- Pin-to-action latency is SYNC_STAGES+1 clk cycles.
- Required MCU timing: `sck` high ≥ 4 clk, low ≥ 4 clk; `ce` setup/hold to the first/last `sck` edge ≥ 4 clk.
- `load` asserts exactly SYNC_STAGES+2 cycles after `ce` falls on a good frame. `key`/`plaintext` are stable from that cycle until the next good frame.
- `ready` rises the cycle after `done` is sampled high in WAIT.
- `sdo` changes SYNC_STAGES+2 cycles after a `sck` falling edge. That is ≤ 4 clk, so it is valid before the next `sck` rise.
- `done` high while not in WAIT is ignored.

## Test plan
- FIPS-197 A.1/B: frame plaintext 3243F6A8885A308D313198A2E0370734 then key 2B7E151628AED2A6ABF7158809CF4F3C, with behavioral `aes_core` stub asserting `done` 12 cycles after `load`.
  - Required: one-cycle `load`, `key`/`plaintext` match the sent values, `ready` rises, and 128-bit readout returns 3925841D02DC09FBDC118597196A0B32.
- Short frame of 200 bits, then `ce` low.
  - Required: `frame_err`=1, no `load`, outputs keep their prior values, state IDLE.
  - A subsequent good frame clears `frame_err`.
- Aborted readout: `ce` drops after 40 bits in TX, then a full readout.
  - Required: `ready` stays 1 and the full readout still returns the 3925841D… value from bit 127.
- `sck`/`ce` toggling during WAIT.
  - Required: no shift, no state change, result unaffected.
- `reset` asserted mid-RX (bit 100) and again mid-WAIT.
  - Required: all outputs at reset values next cycle, late `done` ignored, and the next good frame completes normally.
- Back-to-back: FIPS-197 C.1 frame (plaintext 00112233445566778899AABBCCDDEEFF, key 000102030405060708090A0B0C0D0E0F) immediately after the A.1 readout.
  - Required: readout 69C4E0D86A7B0430D8CDB78070B4C55A.

Source files
------------

// File: rtl/aes_spi_frontend_if.sv
// Pin and core-side bundle of the SPI front end: MCU-facing SPI pins plus the aes_core load/result bus.
// slave = the front end itself; master = whatever drives the pins and models aes_core.
interface aes_spi_frontend_if #(
    parameter int BLOCK_BITS = 128
) ();
    logic                  sck;
    logic                  sdi;
    logic                  ce;
    logic                  sdo;
    logic                  ready;
    logic                  frame_err;
    logic                  load;
    logic                  done;
    logic [BLOCK_BITS-1:0] plaintext;
    logic [BLOCK_BITS-1:0] key;
    logic [BLOCK_BITS-1:0] cyphertext;

    modport slave (
        input  sck, sdi, ce, done, cyphertext,
        output sdo, ready, frame_err, load, plaintext, key
    );

    modport master (
        output sck, sdi, ce, done, cyphertext,
        input  sdo, ready, frame_err, load, plaintext, key
    );
endinterface

// File: rtl/aes_spi_frontend.sv
// Oversampled SPI-slave front end for aes_core: shifts in {plaintext,key}, pulses load, reads cyphertext out on sdo.
// Pin-to-action latency SYNC_STAGES+1 clk; load SYNC_STAGES+2 after ce falls; no backpressure, MCU must meet sck/ce timing.
module aes_spi_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int BLOCK_BITS  = 128
) (
    input  logic               clk,
    input  logic               reset,
    aes_spi_frontend_if.slave  bus
);
    localparam int FRAME_BITS = 2 * BLOCK_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS) + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_BITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;
    localparam logic [2:0] S_TX    = 3'd5;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] ce_sync_q,  ce_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   ce_hist_q,  ce_hist_d;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [BLOCK_BITS-1:0]  pt_q, pt_d;
    logic [BLOCK_BITS-1:0]  key_q, key_d;
    logic [BLOCK_BITS-1:0]  hold_q, hold_d;
    logic [BLOCK_BITS-1:0]  tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic                   load_q, load_d;
    logic                   sdo_q, sdo_d;

    logic sck_s, sdi_s, ce_s;
    logic sck_rise, sck_fall, ce_rise, ce_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign ce_s     = ce_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s &  sck_hist_q;
    assign ce_rise  =  ce_s  & ~ce_hist_q;
    assign ce_fall  = ~ce_s  &  ce_hist_q;

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
        ce_sync_d  = {ce_sync_q[SYNC_STAGES-2:0],  bus.ce};
        sck_hist_d = sck_s;
        ce_hist_d  = ce_s;

        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        pt_d    = pt_q;
        key_d   = key_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        load_d  = 1'b0;

        // sck edges are applied before a ce edge landing in the same cycle
        case (state_q)
            S_IDLE: begin
                if (ce_rise) begin
                    state_d = S_RX;
                    cnt_d   = '0;
                    ferr_d  = 1'b0;
                end
            end
            S_RX: begin
                if (sck_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], sdi_s};
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
                if (ce_fall) begin
                    if (cnt_d == FRAME_CNT) begin
                        state_d = S_START;
                        pt_d    = rx_d[FRAME_BITS-1:BLOCK_BITS];
                        key_d   = rx_d[BLOCK_BITS-1:0];
                    end else begin
                        state_d = S_IDLE;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_START: begin
                load_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // aes_core only sees load at the end of the first WAIT cycle, so a done
                // still high from the previous block must not be taken here
                if (bus.done && !load_q) begin
                    hold_d  = bus.cyphertext;
                    tx_d    = bus.cyphertext;
                    ready_d = 1'b1;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (ce_rise) begin
                    state_d = S_TX;
                    cnt_d   = '0;
                end
            end
            S_TX: begin
                if (sck_fall) begin
                    tx_d = {tx_q[BLOCK_BITS-2:0], 1'b0};
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
                if (ce_fall) begin
                    if (cnt_d >= BLOCK_CNT) begin
                        ready_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        tx_d    = hold_q;
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        sdo_d = ((state_q == S_TX) || (state_q == S_READY)) ? tx_q[BLOCK_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        sck_sync_q <= sck_sync_d;
        sdi_sync_q <= sdi_sync_d;
        ce_sync_q  <= ce_sync_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // history tracks the pins through reset so a ce held high is not seen as a new frame
            sck_hist_q <= sck_hist_d;
            ce_hist_q  <= ce_hist_d;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            pt_q       <= '0;
            key_q      <= '0;
            hold_q     <= '0;
            tx_q       <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            load_q     <= 1'b0;
            sdo_q      <= 1'b0;
        end else begin
            sck_hist_q <= sck_hist_d;
            ce_hist_q  <= ce_hist_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            pt_q       <= pt_d;
            key_q      <= key_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            load_q     <= load_d;
            sdo_q      <= sdo_d;
        end
    end

    assign bus.sdo       = sdo_q;
    assign bus.ready     = ready_q;
    assign bus.frame_err = ferr_q;
    assign bus.load      = load_q;
    assign bus.plaintext = pt_q;
    assign bus.key       = key_q;
endmodule
